layer_load_sequencer: RTL and testbench
=======================================

# layer_load_sequencer

Upstream feeder for the network datapath. Accepts one layer command, then drains a show-ahead DDR3 read FIFO and replays its 32-bit words to the datapath as three consecutive sections (weights, biases, operands), each with its own qualifying strobe. Also drives the datapath's layer select and start pulse, and holds until the datapath reports completion before accepting the next command.

## Interface
- CNT_WIDTH, 16, width of each section word count
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_layer  in  2  0 = Conv, 1 = FC, 2 = AvgPool
- cmd_weight_words / cmd_bias_words / cmd_operand_words  in  CNT_WIDTH each  section lengths in words; 0 = skip section
- rd_data  in  32  FIFO head word (show-ahead)
- rd_empty  in  1  FIFO empty
- rd_en  out  1  pop FIFO head this cycle
- DDR3_Input  out  32  registered data word
- DDR3_weights / DDR3_biases / DDR3_operands  out  1 each  strobe qualifying DDR3_Input
- Layer  out  2  latched cmd_layer
- Start  out  1  one-cycle start pulse
- layer_done  in  1  completion pulse from datapath
- busy  out  1  state != IDLE
- seq_done  out  1  one-cycle pulse on return to IDLE
- stall  in  1  present only with SEQ_STALL_EN

## Operation
- States: IDLE, START, WEIGHTS, BIASES, OPERANDS, WAIT_DONE.
- IDLE: a command is accepted when cmd_valid && cmd_ready. On acceptance, latch Layer and the three counts, then go to START.
- START: lasts one cycle. The next state is the first section with a nonzero count (order: WEIGHTS, BIASES, OPERANDS), or WAIT_DONE if all counts are 0.
- Section states:
  - rd_en = !rd_empty && !stall (combinational).
  - Each rd_en decrements that section's count.
  - An rd_en with count == 1 leaves the section for the next nonzero section, or WAIT_DONE after the last one.
- Pop path: on an rd_en cycle, register DDR3_Input <= rd_data and raise the matching strobe for exactly that one following cycle. At most one strobe is high per cycle.
- DDR3_Input holds its last value when no strobe is high.
- WAIT_DONE: on layer_done, go to IDLE and pulse seq_done. layer_done is ignored in every other state.
- Counts are unsigned. Counts are never decremented below 1 inside a section, so there is no wrap-around.
- FIFO empty mid-section: pause; resume on the next non-empty cycle. No word is lost or duplicated.
- rd_en is never asserted in IDLE, START or WAIT_DONE.

## Timing
- Reset values: state IDLE; cmd_ready 1; rd_en 0; DDR3_Input 0; all strobes 0; Layer 0; Start 0; busy 0; seq_done 0; counts 0.
- Accept edge at cycle T:
  - Start = 1 during T+1 (state START).
  - Earliest rd_en at T+2.
  - Matching strobe and data visible at T+3.
- Throughput: one word per cycle with the FIFO non-empty and no stall. No bubble between sections.
- Last rd_en at cycle N: final strobe at N+1, WAIT_DONE from N+1.
- layer_done sampled at cycle D in WAIT_DONE: seq_done = 1 and cmd_ready = 1 at D+1. Earliest new accept is at D+1.
- Asynchronous reset mid-operation: all outputs return to reset values immediately. FIFO contents are not flushed.

## Configuration
- SEQ_STALL_EN defined: the stall input port exists. When stall is high, rd_en is forced to 0 and counts and state hold. Start and WAIT_DONE behaviour are unaffected.
- SEQ_STALL_EN undefined: no stall port. Behaviour is identical to stall tied to 0.

## Test plan
- Reset: cmd_ready = 1, every other output 0 until the first command.
- Command Layer = 0, counts 3/1/4, FIFO preloaded with 8 words 0x10..0x17, layer_done driven 5 cycles after the last strobe:
  - Start pulses once.
  - DDR3_weights on 0x10..0x12, DDR3_biases on 0x13, DDR3_operands on 0x14..0x17, back-to-back.
  - seq_done one cycle after layer_done.
- Counts 0/0/2 with Layer = 1: no weight or bias strobes; two operand strobes immediately after Start; Layer reads 1 throughout.
- FIFO empty for 3 cycles midway through 4 operand words: rd_en low during the gap; words arrive in order with no duplicates; layer_done pulsed during OPERANDS is ignored.
- All counts 0: Start, then WAIT_DONE with no rd_en; layer_done returns the block to IDLE.
- With SEQ_STALL_EN, stall high for 2 cycles mid-weights: no pops during the stall; the remaining words follow. Separately, reset asserted mid-section: rd_en and strobes drop at once and cmd_ready = 1.

Source files
------------

// File: rtl/layer_load_sequencer.sv
// Layer load sequencer: takes one layer command, drains a show-ahead read FIFO as weight/bias/operand
// sections with per-section strobes, then waits for layer_done. Optional stall input under SEQ_STALL_EN.
module layer_load_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_layer,
  input  logic [CNT_WIDTH-1:0] cmd_weight_words,
  input  logic [CNT_WIDTH-1:0] cmd_bias_words,
  input  logic [CNT_WIDTH-1:0] cmd_operand_words,
  input  logic [31:0]          rd_data,
  input  logic                 rd_empty,
  output logic                 rd_en,
  output logic [31:0]          DDR3_Input,
  output logic                 DDR3_weights,
  output logic                 DDR3_biases,
  output logic                 DDR3_operands,
  output logic [1:0]           Layer,
  output logic                 Start,
  input  logic                 layer_done,
  output logic                 busy,
  output logic                 seq_done,
`ifdef SEQ_STALL_EN
  input  logic                 stall,
`endif
  output logic [2:0]           o_dbg_state
);

  // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WEIGHTS   = 3'd2,
    S_BIASES    = 3'd3,
    S_OPERANDS  = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_w_cnt;
  logic [CNT_WIDTH-1:0] r_b_cnt;
  logic [CNT_WIDTH-1:0] r_o_cnt;
  logic [1:0]           r_layer;
  logic [31:0]          r_data;
  logic                 r_str_w;
  logic                 r_str_b;
  logic                 r_str_o;
  logic                 r_seq_done;
  logic                 w_stall;
  logic                 w_in_section;
  logic                 w_rd_en;

`ifdef SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_in_section = (r_state == S_WEIGHTS) || (r_state == S_BIASES) || (r_state == S_OPERANDS);
  assign w_rd_en      = w_in_section && !rd_empty && !w_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sections are visited in fixed order; a zero count is skipped without spending a cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next = S_START;
      end
      S_START: begin
        if (r_w_cnt != CNT_ZERO)      w_next = S_WEIGHTS;
        else if (r_b_cnt != CNT_ZERO) w_next = S_BIASES;
        else if (r_o_cnt != CNT_ZERO) w_next = S_OPERANDS;
        else                          w_next = S_WAIT_DONE;
      end
      S_WEIGHTS: begin
        if (w_rd_en && (r_w_cnt == CNT_ONE)) begin
          if (r_b_cnt != CNT_ZERO)      w_next = S_BIASES;
          else if (r_o_cnt != CNT_ZERO) w_next = S_OPERANDS;
          else                          w_next = S_WAIT_DONE;
        end
      end
      S_BIASES: begin
        if (w_rd_en && (r_b_cnt == CNT_ONE)) begin
          if (r_o_cnt != CNT_ZERO) w_next = S_OPERANDS;
          else                     w_next = S_WAIT_DONE;
        end
      end
      S_OPERANDS: begin
        if (w_rd_en && (r_o_cnt == CNT_ONE)) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (layer_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_w_cnt <= '0;
      r_b_cnt <= '0;
      r_o_cnt <= '0;
      r_layer <= 2'd0;
    end else if ((r_state == S_IDLE) && cmd_valid) begin
      r_w_cnt <= cmd_weight_words;
      r_b_cnt <= cmd_bias_words;
      r_o_cnt <= cmd_operand_words;
      r_layer <= cmd_layer;
    end else if (w_rd_en) begin
      if (r_state == S_WEIGHTS) r_w_cnt <= r_w_cnt - CNT_ONE;
      if (r_state == S_BIASES)  r_b_cnt <= r_b_cnt - CNT_ONE;
      if (r_state == S_OPERANDS) r_o_cnt <= r_o_cnt - CNT_ONE;
    end
  end

  // Popped word and its strobe appear together one cycle after the pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data     <= 32'h0;
      r_str_w    <= 1'b0;
      r_str_b    <= 1'b0;
      r_str_o    <= 1'b0;
      r_seq_done <= 1'b0;
    end else begin
      if (w_rd_en) r_data <= rd_data;
      r_str_w    <= w_rd_en && (r_state == S_WEIGHTS);
      r_str_b    <= w_rd_en && (r_state == S_BIASES);
      r_str_o    <= w_rd_en && (r_state == S_OPERANDS);
      r_seq_done <= (r_state == S_WAIT_DONE) && layer_done;
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign Start         = (r_state == S_START);
  assign rd_en         = w_rd_en;
  assign DDR3_Input    = r_data;
  assign DDR3_weights  = r_str_w;
  assign DDR3_biases   = r_str_b;
  assign DDR3_operands = r_str_o;
  assign Layer         = r_layer;
  assign seq_done      = r_seq_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_layer_load_sequencer.sv
// Bench for layer_load_sequencer: per-cycle vector tables for the command scenarios, a word scoreboard,
// and a hand-written asynchronous reset sequence. Define SEQ_STALL_EN to add the stall scenario.
module tb_layer_load_sequencer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_layer;
  logic [15:0] cmd_weight_words;
  logic [15:0] cmd_bias_words;
  logic [15:0] cmd_operand_words;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_en;
  logic [31:0] DDR3_Input;
  logic        DDR3_weights;
  logic        DDR3_biases;
  logic        DDR3_operands;
  logic [1:0]  Layer;
  logic        Start;
  logic        layer_done;
  logic        busy;
  logic        seq_done;
  logic        stall;
  logic [2:0]  o_dbg_state;

  layer_load_sequencer #(.CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_layer(cmd_layer),
    .cmd_weight_words(cmd_weight_words), .cmd_bias_words(cmd_bias_words),
    .cmd_operand_words(cmd_operand_words),
    .rd_data(rd_data), .rd_empty(rd_empty), .rd_en(rd_en),
    .DDR3_Input(DDR3_Input), .DDR3_weights(DDR3_weights), .DDR3_biases(DDR3_biases),
    .DDR3_operands(DDR3_operands), .Layer(Layer), .Start(Start),
    .layer_done(layer_done), .busy(busy), .seq_done(seq_done),
`ifdef SEQ_STALL_EN
    .stall(stall),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        cv;
    logic        ld;
    logic        gap;
    logic        stl;
    logic [41:0] exp;
  } vec_t;

  vec_t        vec [0:23];
  int          n_rows;
  int          checks;
  int          errors;
  logic [31:0] fifo_q [$];
  logic [34:0] exp_q [$];
  logic        gap;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // exp packs {cmd_ready, Start, rd_en, weights, biases, operands, busy, seq_done, Layer, DDR3_Input}
  task automatic add_row(input logic cv, input logic ld, input logic gp, input logic st,
                         input logic rdy, input logic stt, input logic rd,
                         input logic sw, input logic sb, input logic so,
                         input logic bz, input logic sd, input logic [1:0] ly, input logic [31:0] d);
    vec[n_rows].cv  = cv;
    vec[n_rows].ld  = ld;
    vec[n_rows].gap = gp;
    vec[n_rows].stl = st;
    vec[n_rows].exp = {rdy, stt, rd, sw, sb, so, bz, sd, ly, d};
    n_rows++;
  endtask

  function automatic logic [41:0] outs();
    return {cmd_ready, Start, rd_en, DDR3_weights, DDR3_biases, DDR3_operands, busy, seq_done, Layer, DDR3_Input};
  endfunction

  task automatic drive_fifo();
    rd_empty = (fifo_q.size() == 0) || gap;
    rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic set_cmd(input logic [1:0] ly, input logic [15:0] w, input logic [15:0] b, input logic [15:0] o);
    cmd_layer = ly; cmd_weight_words = w; cmd_bias_words = b; cmd_operand_words = o;
  endtask

  task automatic load(input logic [31:0] first, input int n, input logic [2:0] tag, input logic track);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + i);
      if (track) exp_q.push_back({tag, first + i});
    end
  endtask

  // scoreboard: every strobe must match the next expected {section, word}
  task automatic monitor(input string nm);
    logic [34:0] e;
    if (DDR3_weights || DDR3_biases || DDR3_operands) begin
      if (exp_q.size() == 0) begin
        check({nm, " unexpected strobe"}, {DDR3_weights, DDR3_biases, DDR3_operands, DDR3_Input}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check({nm, " scoreboard"}, {DDR3_weights, DDR3_biases, DDR3_operands, DDR3_Input}, e);
      end
    end
  endtask

  task automatic run_table(input string scen);
    logic pre;
    for (int i = 0; i < n_rows; i++) begin
      cmd_valid  = vec[i].cv;
      layer_done = vec[i].ld;
      gap        = vec[i].gap;
      stall      = vec[i].stl;
      drive_fifo();
      #1;
      check($sformatf("%s row %0d", scen, i), outs(), vec[i].exp);
      monitor($sformatf("%s row %0d", scen, i));
      pre = rd_en;
      @(posedge clock);
      if (pre) void'(fifo_q.pop_front());
      #1;
    end
    cmd_valid = 1'b0; layer_done = 1'b0; gap = 1'b0; stall = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; gap = 1'b0; stall = 1'b0;
    reset = 1'b1; cmd_valid = 1'b0; layer_done = 1'b0;
    set_cmd(2'd0, 16'd0, 16'd0, 16'd0);
    drive_fifo();
    @(posedge clock); @(posedge clock); #1;
    check("reset outputs", outs(), {1'b1, 41'h0});
    check("reset state", o_dbg_state, 3'd0);
    reset = 1'b0;

    // Conv, 3/1/4, layer_done five cycles after the last strobe
    set_cmd(2'd0, 16'd3, 16'd1, 16'd4);
    load(32'h10, 3, 3'b100, 1'b1);
    load(32'h13, 1, 3'b010, 1'b1);
    load(32'h14, 4, 3'b001, 1'b1);
    n_rows = 0;
    add_row(1,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd0, 32'h0);
    add_row(0,0,0,0, 0,1,0, 0,0,0, 1,0, 2'd0, 32'h0);
    add_row(0,0,0,0, 0,0,1, 0,0,0, 1,0, 2'd0, 32'h0);
    add_row(0,0,0,0, 0,0,1, 1,0,0, 1,0, 2'd0, 32'h10);
    add_row(0,0,0,0, 0,0,1, 1,0,0, 1,0, 2'd0, 32'h11);
    add_row(0,0,0,0, 0,0,1, 1,0,0, 1,0, 2'd0, 32'h12);
    add_row(0,0,0,0, 0,0,1, 0,1,0, 1,0, 2'd0, 32'h13);
    add_row(0,0,0,0, 0,0,1, 0,0,1, 1,0, 2'd0, 32'h14);
    add_row(0,0,0,0, 0,0,1, 0,0,1, 1,0, 2'd0, 32'h15);
    add_row(0,0,0,0, 0,0,1, 0,0,1, 1,0, 2'd0, 32'h16);
    add_row(0,0,0,0, 0,0,0, 0,0,1, 1,0, 2'd0, 32'h17);
    for (int k = 0; k < 4; k++) add_row(0,0,0,0, 0,0,0, 0,0,0, 1,0, 2'd0, 32'h17);
    add_row(0,1,0,0, 0,0,0, 0,0,0, 1,0, 2'd0, 32'h17);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,1, 2'd0, 32'h17);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd0, 32'h17);
    run_table("conv");

    // FC, operands only
    set_cmd(2'd1, 16'd0, 16'd0, 16'd2);
    load(32'h20, 2, 3'b001, 1'b1);
    n_rows = 0;
    add_row(1,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd0, 32'h17);
    add_row(0,0,0,0, 0,1,0, 0,0,0, 1,0, 2'd1, 32'h17);
    add_row(0,0,0,0, 0,0,1, 0,0,0, 1,0, 2'd1, 32'h17);
    add_row(0,0,0,0, 0,0,1, 0,0,1, 1,0, 2'd1, 32'h20);
    add_row(0,0,0,0, 0,0,0, 0,0,1, 1,0, 2'd1, 32'h21);
    add_row(0,1,0,0, 0,0,0, 0,0,0, 1,0, 2'd1, 32'h21);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,1, 2'd1, 32'h21);
    run_table("fc");

    // AvgPool, FIFO gap of three cycles, early layer_done ignored
    set_cmd(2'd2, 16'd0, 16'd0, 16'd4);
    load(32'h30, 4, 3'b001, 1'b1);
    n_rows = 0;
    add_row(1,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd1, 32'h21);
    add_row(0,0,0,0, 0,1,0, 0,0,0, 1,0, 2'd2, 32'h21);
    add_row(0,0,0,0, 0,0,1, 0,0,0, 1,0, 2'd2, 32'h21);
    add_row(0,0,0,0, 0,0,1, 0,0,1, 1,0, 2'd2, 32'h30);
    add_row(0,1,1,0, 0,0,0, 0,0,1, 1,0, 2'd2, 32'h31);
    add_row(0,0,1,0, 0,0,0, 0,0,0, 1,0, 2'd2, 32'h31);
    add_row(0,0,1,0, 0,0,0, 0,0,0, 1,0, 2'd2, 32'h31);
    add_row(0,0,0,0, 0,0,1, 0,0,0, 1,0, 2'd2, 32'h31);
    add_row(0,0,0,0, 0,0,1, 0,0,1, 1,0, 2'd2, 32'h32);
    add_row(0,0,0,0, 0,0,0, 0,0,1, 1,0, 2'd2, 32'h33);
    add_row(0,1,0,0, 0,0,0, 0,0,0, 1,0, 2'd2, 32'h33);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,1, 2'd2, 32'h33);
    run_table("gap");

    // all counts zero with a word waiting in the FIFO: it must stay there
    set_cmd(2'd0, 16'd0, 16'd0, 16'd0);
    load(32'h40, 1, 3'b000, 1'b0);
    n_rows = 0;
    add_row(1,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd2, 32'h33);
    add_row(0,0,0,0, 0,1,0, 0,0,0, 1,0, 2'd0, 32'h33);
    add_row(1,0,0,0, 0,0,0, 0,0,0, 1,0, 2'd0, 32'h33);
    add_row(0,1,0,0, 0,0,0, 0,0,0, 1,0, 2'd0, 32'h33);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,1, 2'd0, 32'h33);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd0, 32'h33);
    run_table("zero");
    fifo_q.delete();

`ifdef SEQ_STALL_EN
    // two stall cycles mid-weights
    set_cmd(2'd0, 16'd4, 16'd0, 16'd0);
    load(32'h60, 4, 3'b100, 1'b1);
    n_rows = 0;
    add_row(1,0,0,0, 1,0,0, 0,0,0, 0,0, 2'd0, 32'h33);
    add_row(0,0,0,0, 0,1,0, 0,0,0, 1,0, 2'd0, 32'h33);
    add_row(0,0,0,0, 0,0,1, 0,0,0, 1,0, 2'd0, 32'h33);
    add_row(0,0,0,0, 0,0,1, 1,0,0, 1,0, 2'd0, 32'h60);
    add_row(0,0,0,1, 0,0,0, 1,0,0, 1,0, 2'd0, 32'h61);
    add_row(0,0,0,1, 0,0,0, 0,0,0, 1,0, 2'd0, 32'h61);
    add_row(0,0,0,0, 0,0,1, 0,0,0, 1,0, 2'd0, 32'h61);
    add_row(0,0,0,0, 0,0,1, 1,0,0, 1,0, 2'd0, 32'h62);
    add_row(0,0,0,0, 0,0,0, 1,0,0, 1,0, 2'd0, 32'h63);
    add_row(0,1,0,0, 0,0,0, 0,0,0, 1,0, 2'd0, 32'h63);
    add_row(0,0,0,0, 1,0,0, 0,0,0, 0,1, 2'd0, 32'h63);
    run_table("stall");
`endif

    check("scoreboard drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a weight section
    set_cmd(2'd1, 16'd4, 16'd0, 16'd0);
    load(32'h50, 4, 3'b000, 1'b0);
    cmd_valid = 1'b1;
    drive_fifo();
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    check("rst seq popping", {rd_en, o_dbg_state}, {1'b1, 3'd2});
    @(posedge clock);
    void'(fifo_q.pop_front());
    #1;
    drive_fifo();
    #1;
    check("rst seq strobe", {DDR3_weights, rd_en, Layer, DDR3_Input}, {1'b1, 1'b1, 2'd1, 32'h50});
    #1;
    reset = 1'b1;
    #1;
    check("rst async outputs", outs(), {1'b1, 41'h0});
    check("rst async state", o_dbg_state, 3'd0);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst idle after", {cmd_ready, busy, rd_en, DDR3_weights}, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
